// File: rtl/conv_pkg.sv
// Shared types for the convolution sequencer: state encoding, address-generator
// base selects and the registered control-strobe bundle.
package conv_pkg;

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    INIT        = 4'd1,
    LOAD_FILTER = 4'd2,
    LOAD_TEMP   = 4'd3,
    VIEW        = 4'd4,
    CALC        = 4'd5,
    PACK        = 4'd6,
    STORE       = 4'd7,
    WRCLR       = 4'd8,
    NEXT        = 4'd9,
    DONE        = 4'd10
  } state_e;

  localparam logic [1:0] SEL_FILTER = 2'b00;
  localparam logic [1:0] SEL_INPUT  = 2'b01;
  localparam logic [1:0] SEL_OUTPUT = 2'b10;

  localparam int NUM_WINDOWS_DEF = 16;

  // Every strobe the FSM drives, registered as one bundle.
  typedef struct packed {
    logic [1:0] sel;
    logic       ldAdr;
    logic       rstX;
    logic       reMem;
    logic       weMem;
    logic       REFilter;
    logic       rstFilter;
    logic       RETemp;
    logic       rstTemp;
    logic       WEview;
    logic       REview;
    logic       rstCalc;
    logic       enCalc;
    logic       ldWR;
    logic       rstWR;
    logic       lastWR;
    logic       busy;
    logic       done;
  } ctrl_t;

endpackage

// File: rtl/conv_win_counter.sv
// Output-window counter; flags the last window of the layer.
module conv_win_counter #(
  parameter int NUM_WINDOWS = 16,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rstN,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WINDOWS - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)          cnt_q <= '0;
    else if (clr_i)     cnt_q <= '0;
    else if (inc_i)     cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  assign last_o = (cnt_q == LAST);

endmodule

// File: rtl/conv_sequencer.sv
// Convolution datapath sequencer: Moore FSM, all strobes registered from the next state.
// Define CONV_SEQ_PERF_CNT_EN to add the cycleCnt/stallCnt performance counters.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int NUM_WINDOWS = NUM_WINDOWS_DEF,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       start,
  input  logic       doneAdr,
  input  logic       fullFilter,
  input  logic       fullTemp,
  input  logic       emptyTemp,
  input  logic       calcDone,
  input  logic       fullWR,
  output logic [1:0] sel,
  output logic       ldAdr,
  output logic       rstX,
  output logic       reMem,
  output logic       weMem,
  output logic       WEFilter,
  output logic       REFilter,
  output logic       rstFilter,
  output logic       WETemp,
  output logic       RETemp,
  output logic       rstTemp,
  output logic       WEview,
  output logic       REview,
  output logic       rstCalc,
  output logic       enCalc,
  output logic       ldWR,
  output logic       rstWR,
  output logic       lastWR,
  output logic       busy,
  output logic       done,
  output logic       err
`ifdef CONV_SEQ_PERF_CNT_EN
  ,
  output logic [15:0] cycleCnt,
  output logic [15:0] stallCnt
`endif
);

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   err_q, err_set;
  logic   rdPipe_q, rdFilt_q;
  logic   last, accept;

  assign accept = (state_q == IDLE) && start;

  conv_win_counter #(.NUM_WINDOWS(NUM_WINDOWS), .CNT_W(CNT_W)) u_win (
    .clk   (clk),
    .rstN  (rstN),
    .clr_i (accept),
    .inc_i (state_q == NEXT),
    .last_o(last)
  );

  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    case (state_q)
      IDLE:        if (start) state_d = INIT;
      INIT:        state_d = LOAD_FILTER;
      // A full flag together with doneAdr is a normal completion.
      LOAD_FILTER: if (fullFilter) state_d = LOAD_TEMP;
                   else if (doneAdr) begin state_d = DONE; err_set = 1'b1; end
      LOAD_TEMP:   if (fullTemp) state_d = VIEW;
                   else if (doneAdr) begin state_d = DONE; err_set = 1'b1; end
      VIEW:        state_d = CALC;
      CALC:        if (calcDone) state_d = PACK;
      PACK:        state_d = (fullWR || last) ? STORE : NEXT;
      STORE:       state_d = WRCLR;
      WRCLR:       state_d = last ? DONE : NEXT;
      NEXT:        state_d = emptyTemp ? LOAD_TEMP : VIEW;
      DONE:        state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    ctrl_d      = '0;
    ctrl_d.busy = (state_d != IDLE);
    case (state_d)
      INIT: begin
        ctrl_d.rstFilter = 1'b1;
        ctrl_d.rstTemp   = 1'b1;
        ctrl_d.rstWR     = 1'b1;
        ctrl_d.rstCalc   = 1'b1;
        ctrl_d.rstX      = 1'b1;
        ctrl_d.ldAdr     = 1'b1;
      end
      LOAD_FILTER: ctrl_d.reMem = 1'b1;
      // First LOAD_TEMP cycle reloads the address base; reads start the cycle after.
      LOAD_TEMP: begin
        ctrl_d.sel   = SEL_INPUT;
        ctrl_d.ldAdr = (state_q != LOAD_TEMP);
        ctrl_d.reMem = (state_q == LOAD_TEMP);
      end
      VIEW: begin
        ctrl_d.RETemp = 1'b1;
        ctrl_d.WEview = 1'b1;
      end
      CALC: begin
        ctrl_d.enCalc   = 1'b1;
        ctrl_d.REview   = 1'b1;
        ctrl_d.REFilter = 1'b1;
      end
      PACK: begin
        ctrl_d.ldWR   = 1'b1;
        ctrl_d.lastWR = last;
      end
      STORE: begin
        ctrl_d.sel   = SEL_OUTPUT;
        ctrl_d.weMem = 1'b1;
      end
      WRCLR:   ctrl_d.rstWR   = 1'b1;
      NEXT:    ctrl_d.rstCalc = 1'b1;
      DONE:    ctrl_d.done    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      err_q    <= 1'b0;
      rdPipe_q <= 1'b0;
      rdFilt_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      // Read data lands one cycle after reMem; tag it by the base it was read from.
      rdPipe_q <= ctrl_q.reMem;
      rdFilt_q <= (ctrl_q.sel == SEL_FILTER);
      if (accept)       err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
    end
  end

  assign sel       = ctrl_q.sel;
  assign ldAdr     = ctrl_q.ldAdr;
  assign rstX      = ctrl_q.rstX;
  assign reMem     = ctrl_q.reMem;
  assign weMem     = ctrl_q.weMem;
  assign WEFilter  = rdPipe_q & rdFilt_q;
  assign REFilter  = ctrl_q.REFilter;
  assign rstFilter = ctrl_q.rstFilter;
  assign WETemp    = rdPipe_q & ~rdFilt_q;
  assign RETemp    = ctrl_q.RETemp;
  assign rstTemp   = ctrl_q.rstTemp;
  assign WEview    = ctrl_q.WEview;
  assign REview    = ctrl_q.REview;
  assign rstCalc   = ctrl_q.rstCalc;
  assign enCalc    = ctrl_q.enCalc;
  assign ldWR      = ctrl_q.ldWR;
  assign rstWR     = ctrl_q.rstWR;
  assign lastWR    = ctrl_q.lastWR;
  assign busy      = ctrl_q.busy;
  assign done      = ctrl_q.done;
  assign err       = err_q;

`ifdef CONV_SEQ_PERF_CNT_EN
  logic [15:0] cycle_q, stall_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cycle_q <= '0;
      stall_q <= '0;
    end else if (accept) begin
      cycle_q <= '0;
      stall_q <= '0;
    end else begin
      if (ctrl_q.busy && cycle_q != 16'hFFFF) cycle_q <= cycle_q + 1'b1;
      if (state_q == CALC && !calcDone && stall_q != 16'hFFFF) stall_q <= stall_q + 1'b1;
    end
  end

  assign cycleCnt = cycle_q;
  assign stallCnt = stall_q;
`endif

endmodule
